// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU trace monitor: FSM state encoding and the trace entry layout.
package cpu_mon_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} mon_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
    logic [XLEN-1:0]       pc;
  } trace_entry_t;
endpackage

// File: rtl/mon_trace_fifo.sv
// Circular first-word-fall-through trace buffer; full pushes either overwrite the
// oldest entry (wrap) or are discarded (stop), flagged on drop_o either way.
module mon_trace_fifo import cpu_mon_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         wrap_mode_i,
  input  trace_entry_t din_i,
  output trace_entry_t dout_o,
  output logic         valid_o,
  output logic [CW-1:0] count_o,
  output logic         drop_o
);
  trace_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          empty, full, pop_ok, wr_en, ovw;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(DEPTH));
  assign pop_ok = pop_i & ~empty;
  // A same-cycle pop frees a slot, so a full push is only lost when nothing leaves.
  assign wr_en  = push_i & (~full | pop_ok | wrap_mode_i);
  assign ovw    = push_i & full & ~pop_ok & wrap_mode_i;
  assign drop_o = push_i & full & ~pop_ok;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en)          wr_d = wr_q + 1'b1;
      if (pop_ok | ovw)   rd_d = rd_q + 1'b1;
      if (wr_en & ~ovw & ~pop_ok)  cnt_d = cnt_q + 1'b1;
      else if (pop_ok & ~wr_en)    cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (wr_en & ~clr_i) mem_q[wr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign valid_o = ~empty;
  assign count_o = cnt_q;
endmodule

// File: rtl/wb_trace_monitor.sv
// Non-intrusive writeback monitor: run/halt/timeout FSM, cycle and writeback counters,
// shadow register file, and a readable trace buffer of captured writebacks.
module wb_trace_monitor #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int TRACE_DEPTH = 16,
  parameter int HALT_CYCLES = 8,
  parameter int MAX_CYCLES  = 1024,
  parameter int CYC_W       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           wrap_mode,
  input  logic [XLEN-1:0]                mon_pc,
  input  logic [XLEN-1:0]                mon_instr,
  input  logic                           mon_wb_en,
  input  logic [REG_ADDR_W-1:0]          mon_wb_addr,
  input  logic [XLEN-1:0]                mon_wb_data,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [REG_ADDR_W-1:0]          rd_addr,
  output logic [XLEN-1:0]                rd_data,
  output logic [XLEN-1:0]                rd_pc,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic [CYC_W-1:0]               dropped,
  output logic [CYC_W-1:0]               cycle_count,
  output logic [CYC_W-1:0]               wb_count,
  output logic [XLEN-1:0]                last_instr,
  output logic                           halted,
  output logic                           timeout,
  input  logic [REG_ADDR_W-1:0]          shadow_rd_addr,
  output logic [XLEN-1:0]                shadow_rd_data
);
  import cpu_mon_pkg::*;

  localparam int SW = $clog2(HALT_CYCLES + 1);
  localparam logic [SW-1:0]    HALT_LIM = SW'(HALT_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LIM  = CYC_W'(MAX_CYCLES - 1);

  mon_state_t       state_q, state_d;
  logic             entry, cap, drop, halt_hit, to_hit;
  logic [SW-1:0]    stab_q, stab_d;
  logic [CYC_W-1:0] cyc_q, cyc_d, wbc_q, wbc_d, drp_q, drp_d;
  logic [XLEN-1:0]  pc_prev_q, instr_q;
  logic [XLEN-1:0]  shadow_q [2**REG_ADDR_W];
  trace_entry_t     push_ent, head;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign entry = (state_q == IDLE) & enable;
  // Capture continues while HALTED so in-flight pipeline writebacks still drain.
  assign cap   = mon_wb_en & (mon_wb_addr != '0) & ((state_q == RUN) | (state_q == HALTED));
  assign push_ent = '{addr: mon_wb_addr, data: mon_wb_data, pc: mon_pc};

  always_comb begin
    stab_d = stab_q;
    cyc_d  = cyc_q;
    wbc_d  = wbc_q;
    drp_d  = drp_q;
    if (entry) begin
      stab_d = '0;
      cyc_d  = '0;
      wbc_d  = '0;
      drp_d  = '0;
    end else begin
      if (state_q == RUN) begin
        cyc_d  = sat_inc(cyc_q);
        stab_d = (mon_pc != pc_prev_q) ? '0 :
                 (stab_q == HALT_LIM)  ? stab_q : stab_q + 1'b1;
      end
      if (cap)  wbc_d = sat_inc(wbc_q);
      if (drop) drp_d = sat_inc(drp_q);
    end
  end

  assign halt_hit = (stab_d == HALT_LIM);
  assign to_hit   = (cyc_d == CYC_LIM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (halt_hit)    state_d = HALTED;
               else if (to_hit) state_d = TIMEOUT;
      default: state_d = state_q;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stab_q    <= '0;
      cyc_q     <= '0;
      wbc_q     <= '0;
      drp_q     <= '0;
      pc_prev_q <= '0;
      instr_q   <= '0;
      for (int i = 0; i < 2**REG_ADDR_W; i++) shadow_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      stab_q    <= stab_d;
      cyc_q     <= cyc_d;
      wbc_q     <= wbc_d;
      drp_q     <= drp_d;
      pc_prev_q <= mon_pc;
      instr_q   <= mon_instr;
      if (cap) shadow_q[mon_wb_addr] <= mon_wb_data;
    end
  end

  mon_trace_fifo #(.DEPTH(TRACE_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (entry),
    .push_i      (cap),
    .pop_i       (rd_ready),
    .wrap_mode_i (wrap_mode),
    .din_i       (push_ent),
    .dout_o      (head),
    .valid_o     (rd_valid),
    .count_o     (trace_count),
    .drop_o      (drop)
  );

  assign rd_addr        = head.addr;
  assign rd_data        = head.data;
  assign rd_pc          = head.pc;
  assign dropped        = drp_q;
  assign cycle_count    = cyc_q;
  assign wb_count       = wbc_q;
  assign last_instr     = instr_q;
  assign halted         = (state_q == HALTED);
  assign timeout        = (state_q == TIMEOUT);
  assign shadow_rd_data = shadow_q[shadow_rd_addr];
endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed bench for wb_trace_monitor: capture order, r0 filter, overflow modes,
// halt, timeout and asynchronous reset.
module tb_wb_trace_monitor;
  localparam int XLEN = 32, RAW = 5, TD = 16, HC = 8, MC = 64, CYC_W = 32;

  logic            clk = 0, rst, enable, wrap_mode, mon_wb_en, rd_ready;
  logic [XLEN-1:0] mon_pc, mon_instr, mon_wb_data;
  logic [RAW-1:0]  mon_wb_addr, shadow_rd_addr;
  logic            rd_valid, halted, timeout;
  logic [RAW-1:0]  rd_addr;
  logic [XLEN-1:0] rd_data, rd_pc, last_instr, shadow_rd_data;
  logic [$clog2(TD):0] trace_count;
  logic [CYC_W-1:0] dropped, cycle_count, wb_count;

  int n_tests = 0, n_fail = 0;
  logic [XLEN-1:0] pc_v;

  always #5 clk = ~clk;

  wb_trace_monitor #(.XLEN(XLEN), .REG_ADDR_W(RAW), .TRACE_DEPTH(TD),
                     .HALT_CYCLES(HC), .MAX_CYCLES(MC), .CYC_W(CYC_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wrap_mode(wrap_mode),
    .mon_pc(mon_pc), .mon_instr(mon_instr), .mon_wb_en(mon_wb_en),
    .mon_wb_addr(mon_wb_addr), .mon_wb_data(mon_wb_data), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_pc(rd_pc),
    .trace_count(trace_count), .dropped(dropped), .cycle_count(cycle_count),
    .wb_count(wb_count), .last_instr(last_instr), .halted(halted), .timeout(timeout),
    .shadow_rd_addr(shadow_rd_addr), .shadow_rd_data(shadow_rd_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with explicit PC and writeback; outputs are sampled 1ns after the edge.
  task automatic cycp(input logic [XLEN-1:0] pc, input logic en,
                      input logic [RAW-1:0] a, input logic [XLEN-1:0] d);
    mon_pc = pc; mon_wb_en = en; mon_wb_addr = a; mon_wb_data = d;
    mon_instr = pc ^ 32'h1300_0000;
    @(posedge clk); #1;
  endtask

  task automatic cyc(input logic en, input logic [RAW-1:0] a, input logic [XLEN-1:0] d);
    cycp(pc_v, en, a, d);
    pc_v = pc_v + 4;
  endtask

  task automatic restart();
    enable = 0; cycp(32'h100, 0, 0, 0);
    enable = 1; cycp(32'h104, 0, 0, 0);
  endtask

  initial begin
    rst = 1; enable = 0; wrap_mode = 0; rd_ready = 0; shadow_rd_addr = 0;
    mon_pc = 0; mon_instr = 0; mon_wb_en = 0; mon_wb_addr = 0; mon_wb_data = 0;
    pc_v = 0;
    #12;
    chk("rst_valid", rd_valid, 0);
    chk("rst_count", trace_count, 0);
    chk("rst_cycles", cycle_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_shadow", shadow_rd_data, 0);
    #1 rst = 0;
    @(posedge clk); #1;

    // Capture order and FWFT read-out
    wrap_mode = 1; restart(); pc_v = 0;
    cyc(1, 1, 32'h11);
    chk("cap_valid_next", rd_valid, 1);
    cyc(1, 2, 32'h22);
    mon_wb_en = 0;
    chk("cap_count", trace_count, 2);
    chk("cap_wbcount", wb_count, 2);
    chk("cap_h0_addr", rd_addr, 1);
    chk("cap_h0_data", rd_data, 32'h11);
    chk("cap_h0_pc", rd_pc, 32'h0);
    chk("last_instr", last_instr, 32'h1300_0004);
    rd_ready = 1; cyc(0, 0, 0);
    chk("cap_h1_addr", rd_addr, 2);
    chk("cap_h1_data", rd_data, 32'h22);
    chk("cap_h1_pc", rd_pc, 32'h4);
    cyc(0, 0, 0); rd_ready = 0;
    chk("cap_empty", rd_valid, 0);
    cyc(0, 0, 0);
    chk("pop_empty_ignored", trace_count, 0);
    shadow_rd_addr = 2; #1;
    chk("shadow_r2", shadow_rd_data, 32'h22);

    // r0 writes are invisible
    restart();
    cyc(1, 0, 32'hDEAD); mon_wb_en = 0;
    shadow_rd_addr = 0; #1;
    chk("r0_count", trace_count, 0);
    chk("r0_wbcount", wb_count, 0);
    chk("r0_shadow", shadow_rd_data, 0);

    // Wrap-mode overflow
    wrap_mode = 1; restart();
    for (int i = 1; i <= 20; i++) cyc(1, RAW'(i), 32'h100 + i);
    mon_wb_en = 0;
    chk("wrap_count", trace_count, 16);
    chk("wrap_dropped", dropped, 4);
    chk("wrap_head", rd_addr, 5);
    chk("wrap_wbcount", wb_count, 20);

    // Stop-mode overflow, then full+push+pop
    wrap_mode = 0; restart();
    for (int i = 1; i <= 20; i++) cyc(1, RAW'(i), 32'h100 + i);
    mon_wb_en = 0;
    chk("stop_count", trace_count, 16);
    chk("stop_dropped", dropped, 4);
    chk("stop_head", rd_addr, 1);
    rd_ready = 1; cyc(1, 21, 32'h115);
    chk("fpp_count", trace_count, 16);
    chk("fpp_dropped", dropped, 4);
    chk("fpp_head", rd_addr, 2);
    repeat (14) cyc(0, 0, 0);
    chk("stop_last_orig", rd_addr, 16);
    cyc(0, 0, 0); rd_ready = 0;
    chk("fpp_new_addr", rd_addr, 21);
    chk("fpp_new_data", rd_data, 32'h115);

    // Halt on stuck PC
    restart();
    cycp(32'h20, 0, 0, 0);
    repeat (HC - 1) cycp(32'h20, 0, 0, 0);
    chk("halt_not_yet", halted, 0);
    cycp(32'h20, 0, 0, 0);
    chk("halt_set", halted, 1);
    chk("halt_cycles", cycle_count, HC + 1);
    cycp(32'h20, 1, 7, 32'h77); mon_wb_en = 0;
    cycp(32'h20, 0, 0, 0);
    shadow_rd_addr = 7; #1;
    chk("halt_cap_count", trace_count, 1);
    chk("halt_cap_addr", rd_addr, 7);
    chk("halt_wbcount", wb_count, 1);
    chk("halt_shadow", shadow_rd_data, 32'h77);
    chk("halt_sticky", halted, 1);
    chk("halt_cyc_frozen", cycle_count, HC + 1);

    // Timeout
    restart();
    repeat (MC - 2) cyc(0, 0, 0);
    chk("to_not_yet", timeout, 0);
    chk("to_cyc62", cycle_count, MC - 2);
    cyc(0, 0, 0);
    chk("to_set", timeout, 1);
    chk("to_cyc63", cycle_count, MC - 1);
    cyc(1, 3, 32'h33); mon_wb_en = 0;
    cyc(0, 0, 0);
    chk("to_no_cap", trace_count, 0);
    chk("to_no_wb", wb_count, 0);
    chk("to_cyc_frozen", cycle_count, MC - 1);
    restart();
    chk("re_timeout", timeout, 0);
    chk("re_cycles", cycle_count, 0);
    cyc(0, 0, 0);
    chk("re_run", cycle_count, 1);

    // Asynchronous reset mid-cycle
    restart();
    for (int i = 1; i <= 5; i++) cyc(1, RAW'(i), 32'h200 + i);
    mon_wb_en = 0; shadow_rd_addr = 3;
    #1;
    chk("ar_pre_count", trace_count, 5);
    chk("ar_pre_shadow", shadow_rd_data, 32'h203);
    #1 rst = 1;
    #1;
    chk("ar_valid", rd_valid, 0);
    chk("ar_count", trace_count, 0);
    chk("ar_wbcount", wb_count, 0);
    chk("ar_cycles", cycle_count, 0);
    chk("ar_shadow", shadow_rd_data, 0);
    chk("ar_data", rd_data, 0);
    #10 rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
